// File: rtl/rect_keysched_dec.sv
// RECTANGLE-80 decryption round-key generator: runs the key schedule forward, then streams K25..K0 back.
// Optional macro RECT_KEYSCHED_SELFCHECK_EN adds chk_err, comparing the recovered state with the loaded key.
module rect_keysched_dec #(
  parameter int         NROUNDS = 25,
  parameter logic [4:0] RC_INIT = 5'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [79:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [63:0] rk_out,
  output logic [4:0]  rk_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy
`ifdef RECT_KEYSCHED_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  rc_q, rc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        key_ready_q, key_ready_d;
  logic        rk_valid_q, rk_valid_d;
  logic        busy_q, busy_d;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
  logic [79:0] key_copy_q, key_copy_d;
  logic        chk_err_q, chk_err_d;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h6;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'hC;  4'h3: sbox = 4'hA;
      4'h4: sbox = 4'h1;  4'h5: sbox = 4'hE;  4'h6: sbox = 4'h7;  4'h7: sbox = 4'h9;
      4'h8: sbox = 4'hB;  4'h9: sbox = 4'h0;  4'hA: sbox = 4'h3;  4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h8;  4'hD: sbox = 4'hF;  4'hE: sbox = 4'h4;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h9;  4'h1: inv_sbox = 4'h4;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'hA;
      4'h4: inv_sbox = 4'hE;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h0;  4'h7: inv_sbox = 4'h6;
      4'h8: inv_sbox = 4'hC;  4'h9: inv_sbox = 4'h7;  4'hA: inv_sbox = 4'h3;  4'hB: inv_sbox = 4'h8;
      4'hC: inv_sbox = 4'h2;  4'hD: inv_sbox = 4'hB;  4'hE: inv_sbox = 4'h5;  default: inv_sbox = 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] rol8(input logic [15:0] x);
    rol8 = {x[7:0], x[15:8]};
  endfunction

  function automatic logic [15:0] rol12(input logic [15:0] x);
    rol12 = {x[3:0], x[15:4]};
  endfunction

  logic [79:0] fwd_sub, fwd_state, inv_pre, inv_state;

  // Column S-box lanes: nibble j is {row3[j],row2[j],row1[j],row0[j]}, only columns 0..3 substituted.
  genvar gi, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [3:0] s_fwd, s_inv;
      assign s_fwd = sbox({key_q[48+gi], key_q[32+gi], key_q[16+gi], key_q[gi]});
      assign s_inv = inv_sbox({inv_pre[48+gi], inv_pre[32+gi], inv_pre[16+gi], inv_pre[gi]});
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign fwd_sub[16*gr+gi]   = s_fwd[gr];
        assign inv_state[16*gr+gi] = s_inv[gr];
      end
    end
    for (gr = 0; gr < 4; gr++) begin : g_pass
      assign fwd_sub[16*gr+15 : 16*gr+4]   = key_q[16*gr+15 : 16*gr+4];
      assign inv_state[16*gr+15 : 16*gr+4] = inv_pre[16*gr+15 : 16*gr+4];
    end
  endgenerate

  assign fwd_sub[79:64]   = key_q[79:64];
  assign inv_state[79:64] = inv_pre[79:64];

  always_comb begin
    fwd_state[15:0]  = rol8(fwd_sub[15:0]) ^ fwd_sub[31:16] ^ {11'd0, rc_q};
    fwd_state[31:16] = fwd_sub[47:32];
    fwd_state[47:32] = fwd_sub[63:48];
    fwd_state[63:48] = rol12(fwd_sub[63:48]) ^ fwd_sub[79:64];
    fwd_state[79:64] = fwd_sub[15:0];
  end

  // Undo the row mixing first; the inverse S-box lanes then operate on inv_pre.
  always_comb begin
    inv_pre[15:0]  = key_q[79:64];
    inv_pre[31:16] = key_q[15:0] ^ {11'd0, rc_q} ^ rol8(key_q[79:64]);
    inv_pre[47:32] = key_q[31:16];
    inv_pre[63:48] = key_q[47:32];
    inv_pre[79:64] = key_q[63:48] ^ rol12(key_q[47:32]);
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
    key_copy_d = key_copy_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = key_in;
          rc_d    = RC_INIT;
          cnt_d   = 5'd0;
          state_d = FWD;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
          key_copy_d = key_in;
          chk_err_d  = 1'b0;
`endif
        end
      end
      FWD: begin
        key_d = fwd_state;
        cnt_d = cnt_q + 5'd1;
        // rc is left on the last forward constant so the first inverse step can reuse it.
        if (cnt_q == 5'(NROUNDS - 1)) begin
          state_d = EMIT;
          idx_d   = 5'(NROUNDS);
        end else begin
          rc_d = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q != 5'd0) begin
            key_d = inv_state;
            idx_d = idx_q - 5'd1;
            rc_d  = {rc_q[0] ^ rc_q[3], rc_q[4:1]};
          end else begin
            state_d = IDLE;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
            if (key_q != key_copy_q) chk_err_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rk_valid_d  = (state_d == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      rc_q        <= RC_INIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
      key_copy_q  <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      rc_q        <= rc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
      key_copy_q  <= key_copy_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = idx_q;
  assign rk_out    = key_q[63:0];
`ifdef RECT_KEYSCHED_SELFCHECK_EN
  assign chk_err   = chk_err_q;
`endif

endmodule

// File: tb/tb_rect_keysched_dec.sv
// Bench for rect_keysched_dec: forward-schedule model builds K0..K25, emitted order checked against it reversed.
module tb_rect_keysched_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] rk_out;
  logic [4:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic        busy;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
  logic        chk_err;
  logic [79:0] corrupt_val;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] key;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_rks[26];

  always #5 clk = ~clk;

  rect_keysched_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
`ifdef RECT_KEYSCHED_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One forward key-schedule round on the whole 80-bit state, written directly from the round rules.
  function automatic logic [79:0] model_fwd(input logic [79:0] s, input logic [4:0] rc);
    logic [15:0] r[5];
    logic [63:0] tbl;
    logic [3:0]  nib, o;
    tbl = 64'h24F8_D30B_97E1_AC56;
    for (int i = 0; i < 5; i++) r[i] = s[16*i +: 16];
    for (int j = 0; j < 4; j++) begin
      nib = {r[3][j], r[2][j], r[1][j], r[0][j]};
      o = tbl[4*nib +: 4];
      r[0][j] = o[0];
      r[1][j] = o[1];
      r[2][j] = o[2];
      r[3][j] = o[3];
    end
    return {r[0],
            ((r[3] << 12) | (r[3] >> 4)) ^ r[4],
            r[3],
            r[2],
            ((r[0] << 8) | (r[0] >> 8)) ^ r[1] ^ {11'd0, rc}};
  endfunction

  task automatic build_expect(input logic [79:0] k);
    logic [79:0] s;
    logic [4:0]  rc;
    s  = k;
    rc = 5'h01;
    for (int i = 0; i < 26; i++) begin
      model_rks[i] = s[63:0];
      if (i < 25) begin
        s  = model_fwd(s, rc);
        rc = {rc[3:0], rc[4] ^ rc[2]};
      end
    end
    for (int i = 25; i >= 0; i--) exp_q.push_back({5'(i), model_rks[i]});
  endtask

  // Compare process: every cycle out of reset, handshake bookkeeping plus emitted key/index.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (key_ready !== !busy) begin
        errors++;
        $display("FAIL ready_vs_busy: key_ready=%b busy=%b", key_ready, busy);
      end
      if (rk_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rk_unexpected: got idx=%0d rk=%h with no key outstanding", rk_idx, rk_out);
        end else begin
          if (rk_idx !== exp_q[0].idx || rk_out !== exp_q[0].key) begin
            errors++;
            $display("FAIL rk_seq: got idx=%0d rk=%h expected idx=%0d rk=%h",
                     rk_idx, rk_out, exp_q[0].idx, exp_q[0].key);
          end
          if (rk_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 of a cycle where the block should be idle.
  task automatic run_job(input logic [79:0] k, input int ready_pct, input int reset_at, input bit corrupt);
    int n;
    int vcount;
    bit forced;
    forced = 1'b0;
    chk("key_ready_when_idle", {79'd0, key_ready}, 80'd1);
    key_in    = k;
    key_valid = 1'b1;
    rk_ready  = (ready_pct == 100);
    build_expect(k);
    @(posedge clk); #1;
    key_in = {16'($urandom), $urandom, $urandom};
    n = 1;
    chk("busy_ignores_key", {78'd0, key_ready, busy}, 80'd1);
    while (!rk_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    key_valid = 1'b0;
    chk("first_valid_latency", 80'(n), 80'd26);
`ifdef RECT_KEYSCHED_SELFCHECK_EN
    chk("chk_err_cleared_on_load", {79'd0, chk_err}, 80'd0);
`endif
    vcount = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      if (reset_at >= 0 && rk_valid && rk_idx == 5'(reset_at)) begin
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_abort_state", {77'd0, rk_valid, key_ready, busy}, 80'b010);
        #2;
        rst_n = 1'b1;
        $display("job key=%h aborted by reset at idx=%0d", k, reset_at);
        return;
      end
      if (rk_valid) vcount++;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
      if (corrupt && rk_valid && rk_idx == 5'd0) begin
        corrupt_val = {~k[79], k[78:0]};
        force dut.key_q = corrupt_val;
        forced = 1'b1;
      end
`endif
      rk_ready = (ready_pct == 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (forced) rk_ready = 1'b1;
      @(posedge clk); #1;
      n++;
`ifdef RECT_KEYSCHED_SELFCHECK_EN
      if (forced) begin
        release dut.key_q;
        forced = 1'b0;
      end
`endif
    end
    chk("all_keys_emitted", 80'(exp_q.size()), 80'd0);
    exp_q.delete();
    if (ready_pct == 100) begin
      chk("full_rate_valid_cycles", 80'(vcount), 80'd26);
      chk("full_rate_total_cycles", 80'(n), 80'd26);
    end
    rk_ready = 1'b0;
    $display("job key=%h ready_pct=%0d emit_cycles=%0d", k, ready_pct, n);
  endtask

  initial begin
    logic [79:0] k;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key_ready", {79'd0, key_ready}, 80'd1);
    chk("reset_rk_valid", {79'd0, rk_valid}, 80'd0);
    chk("reset_rk_idx", {75'd0, rk_idx}, 80'd0);
    chk("reset_rk_out", {16'd0, rk_out}, 80'd0);
    chk("reset_busy", {79'd0, busy}, 80'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(80'd0, 100, -1, 1'b0);
    chk("model_zero_idx1", {16'd0, model_rks[1]}, 80'h0000_0000_000F_000E);
    chk("model_zero_idx0", {16'd0, model_rks[0]}, 80'd0);

    run_job({80{1'b1}}, 100, -1, 1'b0);
    chk("model_ones_idx0", {16'd0, model_rks[0]}, 80'h0000_FFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      k = {16'($urandom), $urandom, $urandom};
      run_job(k, 50, -1, 1'b0);
    end

    k = {16'($urandom), $urandom, $urandom};
    run_job(k, 100, 12, 1'b0);
    k = {16'($urandom), $urandom, $urandom};
    run_job(k, 70, -1, 1'b0);
    k = {16'($urandom), $urandom, $urandom};
    run_job(k, 30, -1, 1'b0);

`ifdef RECT_KEYSCHED_SELFCHECK_EN
    chk("chk_err_normal_run", {79'd0, chk_err}, 80'd0);
    k = {16'($urandom), $urandom, $urandom};
    run_job(k, 100, -1, 1'b1);
    chk("chk_err_after_corrupt", {79'd0, chk_err}, 80'd1);
    k = {16'($urandom), $urandom, $urandom};
    run_job(k, 100, -1, 1'b0);
    chk("chk_err_after_clean_run", {79'd0, chk_err}, 80'd0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_keysched_dec.md
Name: rect_keysched_dec

Overview:
- Sequential RECTANGLE-80 decryption round-key generator.
- Accepts an 80-bit master key, runs the forward key schedule 25 rounds to reach the final key state, then steps the inverse schedule back.
- Streams the 26 round keys K25..K0 in decryption order to the downstream round datapath.
- Each inverse step uses the team's inverse key S-box stage on the low 4 columns.

Parameters:
- NROUNDS, 25, cipher rounds; round keys emitted = NROUNDS+1.
- RC_INIT, 5'h01, initial round-constant LFSR value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  80  master key; row r = key_in[16r+15:16r], r=0..4
- key_valid  in  1  master key offered
- key_ready  out  1  block can accept a key (IDLE only)
- rk_out  out  64  round key {row3,row2,row1,row0} of current state
- rk_idx  out  5  round index of rk_out (25 down to 0)
- rk_valid  out  1  rk_out valid
- rk_ready  in  1  downstream accepts rk_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, key register=0, rc=RC_INIT, round counter=0.
  - key_ready=1, rk_valid=0, rk_idx=0, rk_out=0, busy=0.

- Forward step for round i:
  - S-box on columns j=0..3. Nibble {row3[j],row2[j],row1[j],row0[j]} maps through S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2.
  - Then: row0'=(row0<<<8)^row1; row1'=row2; row2'=row3; row3'=(row3<<<12)^row4; row4'=row0.
  - Then row0'[4:0]^=RC[i].
  - RC update: rc={rc[3:0],rc[4]^rc[2]}.

- Inverse step:
  - row0=row4'; row3=row2'; row2=row1'.
  - row4=row3'^(row2'<<<12).
  - row1=(row0'^RC[i])^(row4'<<<8).
  - Then inverse S-box on columns 0..3.
  - RC steps backward: rc={rc[0]^rc[3],rc[4:1]}.

- FSM:
  - IDLE: key_valid&key_ready loads key_in, sets rc=RC_INIT and cnt=0, then goes to FWD.
  - FWD: one forward step per cycle, cnt++. After step NROUNDS-1 (25 cycles), go to EMIT with rk_idx=25 and rc=RC[24].
  - EMIT: rk_valid=1 and rk_out holds steady while rk_ready=0. On rk_valid&rk_ready:
    - rk_idx>0: apply one inverse step, rk_idx--. The next key is valid the following cycle with no bubble.
    - rk_idx==0: go to IDLE.
- Latency: key accept to first rk_valid is 26 cycles. The 26 keys take 26 cycles at full rk_ready.
- key_valid is ignored outside IDLE.
- rk_ready is ignored outside EMIT.
- Reset asserted mid-FWD or mid-EMIT aborts immediately; no partial keys are emitted afterwards.
- The last key emitted (idx 0) must equal key_in[63:0].

Optional Feature:
- Macro: RECT_KEYSCHED_SELFCHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit).
  - On the idx-0 handshake, the full 80-bit recovered state is compared with a stored copy of key_in.
  - chk_err is set sticky on mismatch. It is cleared by reset or the next key load.
- When undefined: no port, no stored copy, identical timing otherwise.

Test Plan:
- Zero key:
  - key_in=0 -> first rk_valid exactly 26 cycles after accept, rk_idx=25.
  - Second-to-last key (rk_idx=1) = 64'h0000_0000_000F_000E.
  - Last key (rk_idx=0) = 64'h0.
- All-ones key: key_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF, rk_ready=1 -> 26 consecutive rk_valid cycles, idx 25..0. Last rk_out=64'hFFFF_FFFF_FFFF_FFFF.
- Backpressure: rk_ready toggled at random -> rk_out/rk_idx stable while stalled. No key skipped or duplicated; the sequence matches the reference-model list.
- Key offered while busy: key_valid during FWD/EMIT -> key_ready=0, key ignored. A new key is accepted in the IDLE cycle after idx 0.
- Mid-operation reset: rst_n pulsed at EMIT idx=12 -> rk_valid=0 and key_ready=1 immediately. A new key then restarts at idx 25.
- Self-check (macro on): normal run -> chk_err=0. Forcing a corrupt bit in the key register during EMIT -> chk_err=1 after the idx-0 handshake.
